// File: rtl/pcs_rx_pkg.sv
// Shared PCS receive definitions: block-lock states and sync-header codes.
// Imported by the block-lock FSM, BER monitor and decoder.
package pcs_rx_pkg;

  typedef enum logic [1:0] {
    LOCK_INIT,
    TEST,
    SLIP,
    WAIT
  } lock_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  function automatic logic sh_ok(input logic [1:0] h);
    return (h == SH_DATA) || (h == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// 66b receive block-lock FSM for one PCS lane.
// Drives gearbox slip and qualifies the decode path with blk_lock.
module block_lock_fsm
  import pcs_rx_pkg::*;
#(
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 32
) (
  input  logic       clk156,
  input  logic       rstb156,
  input  logic       sh_vld,
  input  logic [1:0] rx_header,
  input  logic       signal_ok,
  output logic       blk_lock,
  output logic       slip,
  output logic       sh_invalid
);

  localparam int SHW = $clog2(LOCK_CNT + 1);
  localparam int IW  = $clog2(INVALID_MAX + 1);
  localparam int WW  = $clog2(SLIP_WAIT + 1);

  localparam logic [SHW-1:0] SH_LAST  = SHW'(LOCK_CNT - 1);
  localparam logic [SHW-1:0] SH_SAT   = SHW'(LOCK_CNT);
  localparam logic [IW-1:0]  INV_LAST = IW'(INVALID_MAX - 1);
  localparam logic [IW-1:0]  INV_SAT  = IW'(INVALID_MAX);
  localparam logic [WW-1:0]  WAIT_LD  = WW'(SLIP_WAIT);

  lock_state_e    state_q;
  logic [SHW-1:0] sh_cnt_q;
  logic [IW-1:0]  inv_cnt_q;
  logic [WW-1:0]  wait_q;
  logic           lock_q;
  logic           slip_q;
  logic           inv_q;

  logic hdr_bad;
  logic win_end;
  logic inv_drop;

  assign hdr_bad  = !sh_ok(rx_header);
  assign win_end  = (sh_cnt_q == SH_LAST);
  assign inv_drop = (inv_cnt_q == INV_LAST);

  always_ff @(posedge clk156) begin
    if (!rstb156 || !signal_ok) begin
      state_q   <= LOCK_INIT;
      sh_cnt_q  <= '0;
      inv_cnt_q <= '0;
      wait_q    <= '0;
      lock_q    <= 1'b0;
      slip_q    <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      slip_q <= 1'b0;
      inv_q  <= 1'b0;
      unique case (state_q)
        LOCK_INIT: begin
          sh_cnt_q  <= '0;
          inv_cnt_q <= '0;
          lock_q    <= 1'b0;
          state_q   <= TEST;
        end
        TEST: begin
          if (sh_vld) begin
            inv_q <= hdr_bad;
            if (hdr_bad && !lock_q) begin
              state_q <= SLIP;
            end else if (hdr_bad && inv_drop) begin
              lock_q  <= 1'b0;
              state_q <= SLIP;
            end else if (win_end) begin
              // Lock only after a fully clean window
              if (!hdr_bad && inv_cnt_q == '0)
                lock_q <= 1'b1;
              sh_cnt_q  <= '0;
              inv_cnt_q <= '0;
            end else begin
              if (sh_cnt_q != SH_SAT)
                sh_cnt_q <= sh_cnt_q + SHW'(1);
              if (hdr_bad && inv_cnt_q != INV_SAT)
                inv_cnt_q <= inv_cnt_q + IW'(1);
            end
          end
        end
        SLIP: begin
          slip_q    <= 1'b1;
          sh_cnt_q  <= '0;
          inv_cnt_q <= '0;
          wait_q    <= WAIT_LD;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (wait_q == '0)
            state_q <= TEST;
          else
            wait_q <= wait_q - WW'(1);
        end
      endcase
    end
  end

  assign blk_lock   = lock_q;
  assign slip       = slip_q;
  assign sh_invalid = inv_q;

endmodule

// File: tb/tb_block_lock_fsm.sv
// Self-checking bench for block_lock_fsm: vector table plus
// hand-written multi-cycle sequences, checked through a scoreboard queue.
module tb_block_lock_fsm;
  import pcs_rx_pkg::*;

  logic       clk156 = 1'b0;
  logic       rstb156 = 1'b0;
  logic       sh_vld = 1'b0;
  logic [1:0] rx_header = SH_DATA;
  logic       signal_ok = 1'b1;
  logic       blk_lock;
  logic       slip;
  logic       sh_invalid;

  block_lock_fsm dut (
    .clk156    (clk156),
    .rstb156   (rstb156),
    .sh_vld    (sh_vld),
    .rx_header (rx_header),
    .signal_ok (signal_ok),
    .blk_lock  (blk_lock),
    .slip      (slip),
    .sh_invalid(sh_invalid)
  );

  always #5 clk156 = ~clk156;

  typedef struct {
    logic [2:0] exp;
    string      tag;
  } sb_t;

  typedef struct {
    logic       rn;
    logic       sok;
    logic       vld;
    logic [1:0] hdr;
    logic       lock;
    logic       slp;
    logic       inv;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[14];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [1:0] vh(input int i);
    return i[0] ? SH_CTRL : SH_DATA;
  endfunction

  // Drive one cycle of inputs; expectation is for outputs after the edge.
  task automatic cyc(input logic rn, input logic sok, input logic vld,
                     input logic [1:0] hdr, input logic el,
                     input logic es, input logic ei, input string tag);
    sb_t e;
    sb_t g;
    rstb156   = rn;
    signal_ok = sok;
    sh_vld    = vld;
    rx_header = hdr;
    e.exp = {el, es, ei};
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk156);
    #1;
    g = sbq.pop_front();
    checks++;
    if ({blk_lock, slip, sh_invalid} === g.exp)
      passed++;
    else
      $display("FAIL %s: lock/slip/inv got %b%b%b want %b",
               g.tag, blk_lock, slip, sh_invalid, g.exp);
    @(negedge clk156);
  endtask

  task automatic acquire(input string tag);
    for (int i = 0; i < 64; i++)
      cyc(1, 1, 1, vh(i), (i == 63), 0, 0, tag);
  endtask

  // Slip gap: headers offered here, including invalid ones, must be ignored.
  task automatic wait_gap(input string tag);
    for (int i = 0; i < 33; i++)
      cyc(1, 1, 1, 2'b00, 0, 0, 0, tag);
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++)
      vt[2+i] = '{1'b1, 1'b1, 1'b1, vh(i), 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b1, 1'b1, SH_DATA, 1'b0, 1'b1, 1'b0};

    @(negedge clk156);
    for (int i = 0; i < 14; i++)
      cyc(vt[i].rn, vt[i].sok, vt[i].vld, vt[i].hdr,
          vt[i].lock, vt[i].slp, vt[i].inv, "vec");

    wait_gap("wait_ignore");
    acquire("relock_after_slip");

    for (int i = 0; i < 64; i++) begin
      automatic logic bad = (i % 4 == 1) && (i < 58);
      cyc(1, 1, 1, bad ? 2'b00 : vh(i), 1, 0, bad, "win15");
    end
    for (int i = 0; i < 15; i++)
      cyc(1, 1, 1, 2'b11, 1, 0, 1, "win16");
    cyc(1, 1, 1, 2'b11, 0, 0, 1, "drop");
    cyc(1, 1, 1, SH_DATA, 0, 1, 0, "drop_slip");
    wait_gap("drop_wait");
    acquire("relock_after_drop");

    for (int i = 0; i < 20; i++)
      cyc(1, 1, 1, vh(i), 1, 0, 0, "locked_mid");
    cyc(1, 0, 1, SH_DATA, 0, 0, 0, "sigok_low");
    cyc(1, 1, 1, SH_CTRL, 0, 0, 0, "sigok_init");
    acquire("relock_sigok");

    cyc(1, 0, 0, SH_DATA, 0, 0, 0, "unlock");
    cyc(1, 1, 0, SH_DATA, 0, 0, 0, "unlock_init");
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 1, vh(i), 0, 0, 0, "pre_slip");
    cyc(1, 1, 1, 2'b00, 0, 0, 1, "bad_hdr");
    cyc(1, 1, 0, SH_DATA, 0, 1, 0, "slip");
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 1, SH_DATA, 0, 0, 0, "in_wait");
    cyc(0, 1, 1, SH_DATA, 0, 0, 0, "rst_wait");
    cyc(1, 1, 0, SH_DATA, 0, 0, 0, "rst_init");
    acquire("acq_after_rst");

    cyc(0, 1, 0, SH_DATA, 0, 0, 0, "rst2");
    cyc(1, 1, 0, SH_DATA, 0, 0, 0, "rst2_init");
    cyc(1, 1, 1, 2'b11, 0, 0, 1, "bad_hdr2");
    cyc(0, 1, 1, SH_DATA, 0, 0, 0, "rst_in_slip");
    cyc(1, 1, 0, SH_DATA, 0, 0, 0, "rst3_init");
    for (int i = 0; i < 64; i++) begin
      cyc(1, 1, 1, vh(i), (i == 63), 0, 0, "gapped");
      for (int k = 0; k < 2; k++)
        cyc(1, 1, 0, 2'b11, (i == 63), 0, 0, "gapped_idle");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
